// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and hold-counter helper for the sprite motion controller.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 14;
  localparam int SPRITE_H = 14;
  localparam int X_MAX    = SCREEN_W - SPRITE_W;
  localparam int Y_MAX    = SCREEN_H - SPRITE_H;

  localparam int EDGE_TOP    = 3;
  localparam int EDGE_BOTTOM = 2;
  localparam int EDGE_LEFT   = 1;
  localparam int EDGE_RIGHT  = 0;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTN    = 5;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CALC,
    CLAMP,
    COMMIT
  } state_e;

  // Next hold count for one axis: restart on release, conflict or reversal,
  // otherwise count up and saturate at sat.
  function automatic logic [4:0] hold_next(
    input logic [4:0] cnt,
    input logic       neg,
    input logic       pos,
    input logic       prev_neg,
    input logic       prev_pos,
    input logic [4:0] sat
  );
    if (neg == pos) return 5'd0;
    if ((prev_neg != prev_pos) && (prev_pos != pos)) return 5'd0;
    if (cnt >= sat) return sat;
    return cnt + 5'd1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw, asynchronous button line.
module btn_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position update: sample buttons, step with hold-to-accelerate,
// clamp to the visible area and commit during vertical blanking.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int HOME_X       = 313,
  parameter int HOME_Y       = 233,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 4,
  parameter int ACCEL_FRAMES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       frame_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [9:0] blue_square_x,
  output logic [8:0] blue_square_y,
  output logic       update_done,
  output logic [3:0] at_edge
);

  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
  localparam logic [4:0]         ACCEL   = 5'(ACCEL_FRAMES);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_s;
  logic [NUM_BTN-1:0] btn_q;

  state_e state_q, state_d;

  logic [4:0]         cnt_x_q, cnt_y_q;
  logic signed [11:0] cand_x_q, cand_y_q, cand_x_d, cand_y_d;
  logic signed [11:0] step_x, step_y, x_ext, y_ext;
  logic [9:0]         x_q, x_clamp_d;
  logic [8:0]         y_q, y_clamp_d;
  logic               done_q;
  logic [3:0]         edge_q, edge_d;

  assign btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_sync
    btn_sync u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (btn_raw[gi]),
      .q_o   (btn_s[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = SAMPLE;
      SAMPLE:  state_d = CALC;
      CALC:    state_d = CLAMP;
      CLAMP:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ext  = signed'({2'b00, x_q});
    y_ext  = signed'({3'b000, y_q});
    step_x = (cnt_x_q == ACCEL) ? 12'(STEP_FAST) : 12'(STEP_SLOW);
    step_y = (cnt_y_q == ACCEL) ? 12'(STEP_FAST) : 12'(STEP_SLOW);

    cand_x_d = x_ext;
    if (btn_q[BTN_RIGHT] && !btn_q[BTN_LEFT])      cand_x_d = x_ext + step_x;
    else if (btn_q[BTN_LEFT] && !btn_q[BTN_RIGHT]) cand_x_d = x_ext - step_x;

    cand_y_d = y_ext;
    if (btn_q[BTN_DOWN] && !btn_q[BTN_UP])      cand_y_d = y_ext + step_y;
    else if (btn_q[BTN_UP] && !btn_q[BTN_DOWN]) cand_y_d = y_ext - step_y;

    if (btn_q[BTN_CENTER]) begin
      cand_x_d = 12'(HOME_X);
      cand_y_d = 12'(HOME_Y);
    end
  end

  always_comb begin
    if (cand_x_q < 12'sd0)        x_clamp_d = '0;
    else if (cand_x_q > X_MAX_S)  x_clamp_d = 10'(X_MAX);
    else                          x_clamp_d = cand_x_q[9:0];

    if (cand_y_q < 12'sd0)        y_clamp_d = '0;
    else if (cand_y_q > Y_MAX_S)  y_clamp_d = 9'(Y_MAX);
    else                          y_clamp_d = cand_y_q[8:0];

    edge_d              = '0;
    edge_d[EDGE_TOP]    = (y_clamp_d == '0);
    edge_d[EDGE_BOTTOM] = (y_clamp_d == 9'(Y_MAX));
    edge_d[EDGE_LEFT]   = (x_clamp_d == '0);
    edge_d[EDGE_RIGHT]  = (x_clamp_d == 10'(X_MAX));
    if (btn_q[BTN_CENTER]) edge_d = '0;
  end

  // Outputs load on the CLAMP->COMMIT edge so they are visible during COMMIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      btn_q    <= '0;
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      x_q      <= 10'(HOME_X);
      y_q      <= 9'(HOME_Y);
      done_q   <= 1'b0;
      edge_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        SAMPLE: begin
          btn_q   <= btn_s;
          cnt_x_q <= btn_s[BTN_CENTER] ? 5'd0 :
                     hold_next(cnt_x_q, btn_s[BTN_LEFT], btn_s[BTN_RIGHT],
                               btn_q[BTN_LEFT], btn_q[BTN_RIGHT], ACCEL);
          cnt_y_q <= btn_s[BTN_CENTER] ? 5'd0 :
                     hold_next(cnt_y_q, btn_s[BTN_UP], btn_s[BTN_DOWN],
                               btn_q[BTN_UP], btn_q[BTN_DOWN], ACCEL);
        end
        CALC: begin
          cand_x_q <= cand_x_d;
          cand_y_q <= cand_y_d;
        end
        CLAMP: begin
          x_q    <= x_clamp_d;
          y_q    <= y_clamp_d;
          edge_q <= edge_d;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign blue_square_x = x_q;
  assign blue_square_y = y_q;
  assign update_done   = done_q;
  assign at_edge       = edge_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed scoreboard bench for sprite_motion_ctrl: each frame pushes its expected commit.
module tb_sprite_motion_ctrl;

  logic       CLK;
  logic       RST;
  logic       frame_start;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [9:0] blue_square_x;
  logic [8:0] blue_square_y;
  logic       update_done;
  logic [3:0] at_edge;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] e;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_upd = 0;
  int u0    = 0;

  // reference model state
  int mx = 313, my = 233, mcx = 0, mcy = 0, pdx = 0, pdy = 0;

  sprite_motion_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .frame_start   (frame_start),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_center    (btn_center),
    .blue_square_x (blue_square_x),
    .blue_square_y (blue_square_y),
    .update_done   (update_done),
    .at_edge       (at_edge)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0 && update_done === 1'b1) begin
      n_upd++;
      if (sb_q.size() == 0) begin
        check("spurious_update", 32'(update_done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("x", 32'(blue_square_x), 32'(mon_e.x));
        check("y", 32'(blue_square_y), 32'(mon_e.y));
        check("at_edge", 32'(at_edge), 32'(mon_e.e));
        check("latency", 32'(cyc), 32'(mon_e.cyc));
        $display("commit cyc=%0d x=%0d y=%0d at_edge=%b", cyc, blue_square_x, blue_square_y, at_edge);
      end
    end
  end

  function automatic int next_hold(int cnt, logic neg, logic pos, int pdir);
    int dir;
    if (neg == pos) return 0;
    dir = pos ? 1 : -1;
    if (pdir != 0 && pdir != dir) return 0;
    return (cnt >= 16) ? 16 : cnt + 1;
  endfunction

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = 313; my = 233; mcx = 0; mcy = 0; pdx = 0; pdy = 0;
  endtask

  task automatic model_push(input logic u, input logic d, input logic l, input logic r, input logic c);
    exp_t e;
    int sx, sy;
    if (c) begin
      mx = 313; my = 233; mcx = 0; mcy = 0;
      e.e = 4'b0000;
    end else begin
      mcx = next_hold(mcx, l, r, pdx);
      mcy = next_hold(mcy, u, d, pdy);
      sx = (mcx == 16) ? 4 : 1;
      sy = (mcy == 16) ? 4 : 1;
      if (r && !l) mx = clampi(mx + sx, 626);
      else if (l && !r) mx = clampi(mx - sx, 626);
      if (d && !u) my = clampi(my + sy, 466);
      else if (u && !d) my = clampi(my - sy, 466);
      e.e = {my == 0, my == 466, mx == 0, mx == 626};
    end
    pdx = (l ^ r) ? (r ? 1 : -1) : 0;
    pdy = (u ^ d) ? (d ? 1 : -1) : 0;
    e.x = 10'(mx);
    e.y = 9'(my);
    e.cyc = cyc + 4;
    sb_q.push_back(e);
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r, input logic c);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_center = c;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(posedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      check("update_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic frame(input logic u, input logic d, input logic l, input logic r, input logic c);
    set_btn(u, d, l, r, c);
    repeat (3) @(posedge CLK);
    #1;
    model_push(u, d, l, r, c);
    frame_start = 1'b1;
    @(posedge CLK);
    #1 frame_start = 1'b0;
    drain();
  endtask

  initial begin
    RST = 1'b1;
    frame_start = 1'b0;
    set_btn(0, 0, 0, 0, 0);

    // 1: reset state
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t1_x", 32'(blue_square_x), 32'd313);
    check("t1_y", 32'(blue_square_y), 32'd233);
    check("t1_done", 32'(update_done), 32'd0);
    check("t1_edge", 32'(at_edge), 32'd0);

    // 2: right held 20 frames, acceleration after 16
    for (int i = 0; i < 20; i++) frame(0, 0, 0, 1, 0);
    check("t2_x", 32'(blue_square_x), 32'd348);

    // 3: walk to x=622 with saturated counter, then hit the right edge
    frame(0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) frame(0, 0, 0, 1, 0);
    frame(0, 0, 0, 0, 0);
    for (int i = 0; i < 76; i++) frame(0, 0, 0, 1, 0);
    check("t3_x_start", 32'(blue_square_x), 32'd622);
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 1, 0);
    check("t3_x_clamped", 32'(blue_square_x), 32'd626);
    check("t3_edge_right", 32'(at_edge[0]), 32'd1);
    frame(0, 0, 1, 0, 0);
    check("t3_x_left", 32'(blue_square_x), 32'd625);
    check("t3_edge_right_clr", 32'(at_edge[0]), 32'd0);

    // 4: up+down conflict
    for (int i = 0; i < 5; i++) frame(1, 1, 0, 0, 0);
    check("t4_y_conflict", 32'(blue_square_y), 32'd233);
    frame(1, 0, 0, 0, 0);
    check("t4_y_slow", 32'(blue_square_y), 32'd232);

    // 5: top edge, then centre priority
    for (int i = 0; i < 80; i++) frame(1, 0, 0, 0, 0);
    check("t5_y_top", 32'(blue_square_y), 32'd0);
    frame(1, 0, 0, 0, 0);
    check("t5_y_no_underflow", 32'(blue_square_y), 32'd0);
    check("t5_edge_top", 32'(at_edge[3]), 32'd1);
    frame(0, 1, 0, 0, 1);
    check("t5_home_x", 32'(blue_square_x), 32'd313);
    check("t5_home_y", 32'(blue_square_y), 32'd233);
    check("t5_edge_clr", 32'(at_edge), 32'd0);

    // 6a: frame_start during CALC is ignored
    u0 = n_upd;
    set_btn(0, 0, 0, 1, 0);
    repeat (3) @(posedge CLK);
    #1;
    model_push(0, 0, 0, 1, 0);
    frame_start = 1'b1;
    @(posedge CLK);
    #1 frame_start = 1'b0;
    @(posedge CLK);
    #1 frame_start = 1'b1;
    @(posedge CLK);
    #1 frame_start = 1'b0;
    drain();
    repeat (10) @(posedge CLK);
    #1;
    check("t6_single_update", 32'(n_upd - u0), 32'd1);
    check("t6_x", 32'(blue_square_x), 32'd314);

    // 6b: reset during CLAMP aborts the update
    u0 = n_upd;
    repeat (3) @(posedge CLK);
    #1 frame_start = 1'b1;
    @(posedge CLK);
    #1 frame_start = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    set_btn(0, 0, 0, 0, 0);
    repeat (6) @(posedge CLK);
    #1;
    check("t6_rst_x", 32'(blue_square_x), 32'd313);
    check("t6_rst_y", 32'(blue_square_y), 32'd233);
    check("t6_rst_edge", 32'(at_edge), 32'd0);
    check("t6_rst_no_update", 32'(n_upd - u0), 32'd0);
    frame(0, 0, 0, 0, 0);
    check("t6_idle_frame_update", 32'(n_upd - u0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
